cruise_stalk_encoder: RTL
=========================

# cruise_stalk_encoder

Front end for the cruise controller's driver-input interface. It takes raw pedal and stalk-switch levels and produces the clean, clock-aligned command signals the controller consumes: `throttle` and `brake` as levels; `set`, `accel`, `coast`, `cancel` and `resume` as single-cycle pulses. It synchronises and debounces every input, generates edge pulses, auto-repeats `accel`/`coast` while held, and enforces mutual exclusion and priority so the controller never sees conflicting commands.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed to accept a new level (1..255).
- `REPEAT_DELAY`, default 8: cycles from the first `accel`/`coast` pulse to the first repeat (1..255).
- `REPEAT_PERIOD`, default 4: cycles between subsequent repeats (1..255).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `throttle_raw`, `brake_raw`, `set_raw`, `accel_raw`, `coast_raw`, `cancel_raw`, `resume_raw` in 1 each: asynchronous switch levels, active-high.
- `throttle` out 1: debounced throttle level.
- `brake` out 1: debounced brake level.
- `set`, `accel`, `coast`, `cancel`, `resume` out 1 each: one-cycle command pulses.
- `accel_coast_conflict` out 1: high while debounced accel and coast are both high.

## Operation
- **Sync:** each raw input passes through a 2-flop synchroniser.
- **Debounce:** each input has an 8-bit counter.
  - When the synced level differs from the debounced level, the counter increments; when it equals it, the counter clears.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A one-cycle glitch restarts the count.
- **Level outputs:** `throttle` and `brake` are registered copies of the debounced levels.
- **Arming (set, accel, coast, cancel, resume):**
  - After reset, each pulse input is disarmed.
  - It arms once its debounced level has been low for at least one cycle.
  - A rising debounced edge produces a candidate pulse only if the input is armed. A switch held through reset therefore never fires.
- **Auto-repeat (accel, coast):**
  - A repeat counter starts on the first candidate.
  - While the debounced level stays high, extra candidates occur at `REPEAT_DELAY` after the first, then every `REPEAT_PERIOD`.
  - A debounced fall stops repeats immediately and clears the counter.
- **Conflict:** while debounced accel and coast are both high:
  - no accel or coast candidates are generated;
  - both repeat counters are held at 0;
  - `accel_coast_conflict` is 1.
  - After the conflict, the still-held input produces no pulse until it is released and pressed again.
- **Arbitration:** at most one pulse output is high per cycle. Priority is `cancel` > `set` > `resume` > `accel` > `coast`.
  - Losing candidates are dropped, not deferred.
  - A dropped repeat does not shift the repeat schedule.
- **Brake override:** while debounced brake is 1, all `set`/`resume`/`accel`/`coast` candidates are dropped and repeat counters are held at 0. `cancel` is still passed.

## Timing
- Reset value: every output is 0. Synchronisers, debounced levels, counters and arm flags are also 0.
- Latency: take the first edge that samples a new raw level as edge 0. The matching level output changes, or the pulse appears, on edge `DEBOUNCE_CYCLES`+2 (edge 6 with defaults).
- All outputs come directly from flops; there are no combinational paths from input to output.
- A pulse is exactly one cycle wide. The next pulse from the same input needs a debounced fall and rise, or a repeat slot.
- Reset asserted mid-operation clears everything on the next edge. Pending candidates and repeat phase are lost, and arming restarts.
- When brake is released while accel is still held, accel produces no pulse and no repeats until it is released and pressed again.

## Configuration
- `STALK_AUTOREPEAT_EN` defined: auto-repeat of `accel`/`coast` as described above.
- Not defined: exactly one pulse per debounced press, with no repeat counters. `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
- **Basic press:** reset released, `set_raw` low 3 cycles then high 10 cycles -> `set` high for exactly 1 cycle, on edge 6 after the first high sample, with no other outputs.
- **Glitch rejection:** `throttle_raw` high 3 cycles, low 1, high 6 -> `throttle` rises only on the 6th edge after the second rising sample.
- **Auto-repeat:** `accel_raw` held 40 cycles with `STALK_AUTOREPEAT_EN` -> pulses at T, T+8, T+12, T+16, and so on until release. Without the macro -> only the pulse at T.
- **Priority:** `cancel_raw` and `set_raw` rise in the same cycle -> only `cancel` pulses. `set` is dropped and does not appear later.
- **Brake override:** `brake_raw` high, then `resume_raw` pressed -> `resume` stays 0 and `brake` = 1. `cancel_raw` pressed during brake -> `cancel` pulses.
- **Reset arming:** `coast_raw` held high through reset and for 20 cycles after -> no `coast` pulse. Release then press again -> one pulse. Accel and coast held together -> `accel_coast_conflict` = 1 and neither `accel` nor `coast` pulses.

Source files
------------

// File: rtl/cruise_stalk_encoder.sv
// cruise_stalk_encoder
// Driver-input front end for the cruise controller: synchronises and
// debounces the pedal/stalk switches, turns the stalk switches into
// one-cycle command pulses, and arbitrates them so that at most one
// command reaches the controller per cycle.
// Optional feature macro: STALK_AUTOREPEAT_EN (auto-repeat of accel/coast).
//
// Arming rule: a pulse input arms only after the synchroniser holds a
// genuine low sample while its debounced level is low. The reset zeros
// still sitting in the synchroniser do not count, so a switch held through
// reset never fires. Brake (for set/resume/accel/coast) and an accel+coast
// conflict (for accel/coast) disarm the affected inputs. The switch must
// then be released and pressed again before it fires.
module cruise_stalk_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic throttle_raw,
  input  logic brake_raw,
  input  logic set_raw,
  input  logic accel_raw,
  input  logic coast_raw,
  input  logic cancel_raw,
  input  logic resume_raw,
  output logic throttle,
  output logic brake,
  output logic set,
  output logic accel,
  output logic coast,
  output logic cancel,
  output logic resume,
  output logic accel_coast_conflict
);

  // Raw-vector bit positions
  localparam int THR = 0;
  localparam int BRK = 1;
  localparam int ACC = 3;
  localparam int CST = 4;
  // Pulse-vector bit positions (pulse vector = raw vector bits [6:2])
  localparam int P_SET = 0;
  localparam int P_ACC = 1;
  localparam int P_CST = 2;
  localparam int P_CAN = 3;
  localparam int P_RES = 4;

  // Elaboration-time range check of the configuration
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_cfg_check
    $error("cruise_stalk_encoder: parameter out of range 1..255");
  end

  logic [6:0] w_raw;
  logic [6:0] r_sync1;
  logic [6:0] r_sync2;
  logic [6:0] r_deb;
  logic [6:0] r_deb_d;
  logic [7:0] r_cnt [7];
  logic [1:0] r_live;
  logic [4:0] r_armed;
  logic [4:0] r_pulse;
  logic       r_throttle;
  logic       r_brake;
  logic       r_conflict;

  logic       w_brake;
  logic       w_conflict;
  logic [4:0] w_rise;
  logic [4:0] w_kill;
  logic [4:0] w_arm_ok;
  logic [4:0] w_first;
  logic [4:0] w_cand;
  logic [4:0] w_grant;

  assign w_raw = {resume_raw, cancel_raw, coast_raw, accel_raw,
                  set_raw, brake_raw, throttle_raw};

  // Two-flop synchroniser; r_live marks when r_sync2 holds a real sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_live  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_live  <= {r_live[0], 1'b1};
    end
  end

  // Debounce: flip after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 7; i++) r_cnt[i] <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 7; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_brake    = r_deb[BRK];
  assign w_conflict = r_deb[ACC] & r_deb[CST];
  assign w_rise     = r_deb[6:2] & ~r_deb_d[6:2];
  // Inputs blocked this cycle: brake blocks all but cancel, conflict blocks accel/coast
  assign w_kill     = {w_brake, 1'b0, w_brake | w_conflict,
                       w_brake | w_conflict, w_brake};
  assign w_arm_ok   = {5{r_live[1]}} & ~r_deb[6:2] & ~r_sync2[6:2];
  assign w_first    = w_rise & r_armed & ~w_kill;

  // Arm flags: set by a genuine low, cleared while the input is blocked
  always_ff @(posedge clk) begin
    if (reset) r_armed <= '0;
    else       r_armed <= (r_armed | w_arm_ok) & ~w_kill;
  end

`ifdef STALK_AUTOREPEAT_EN
  // Index 0 = accel, 1 = coast
  logic [1:0] r_rep_act;
  logic [1:0] r_rep_first;
  logic [7:0] r_rep_cnt [2];
  logic [1:0] w_rep_hit;

  // Repeat slot: counter reached the delay (first) or the period (later)
  always_comb begin
    w_rep_hit = '0;
    for (int j = 0; j < 2; j++) begin
      if (r_rep_act[j] && r_deb[ACC + j] && !w_kill[P_ACC + j] &&
          (r_rep_cnt[j] == (r_rep_first[j] ? 8'(REPEAT_DELAY) : 8'(REPEAT_PERIOD))))
        w_rep_hit[j] = 1'b1;
    end
  end

  // Repeat counters: start on first press, stop on release or block
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep_act   <= '0;
      r_rep_first <= '0;
      for (int j = 0; j < 2; j++) r_rep_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (w_first[P_ACC + j]) begin
          r_rep_act[j]   <= 1'b1;
          r_rep_first[j] <= 1'b1;
          r_rep_cnt[j]   <= 8'd1;
        end else if (!r_deb[ACC + j] || w_kill[P_ACC + j]) begin
          r_rep_act[j]   <= 1'b0;
          r_rep_first[j] <= 1'b0;
          r_rep_cnt[j]   <= '0;
        end else if (r_rep_act[j]) begin
          if (w_rep_hit[j]) begin
            r_rep_first[j] <= 1'b0;
            r_rep_cnt[j]   <= 8'd1;
          end else begin
            r_rep_cnt[j]   <= r_rep_cnt[j] + 8'd1;
          end
        end
      end
    end
  end

  assign w_cand = w_first | {2'b00, w_rep_hit, 1'b0};
`else
  assign w_cand = w_first;
`endif

  // Fixed-priority arbitration: cancel > set > resume > accel > coast
  always_comb begin
    w_grant = '0;
    if      (w_cand[P_CAN]) w_grant[P_CAN] = 1'b1;
    else if (w_cand[P_SET]) w_grant[P_SET] = 1'b1;
    else if (w_cand[P_RES]) w_grant[P_RES] = 1'b1;
    else if (w_cand[P_ACC]) w_grant[P_ACC] = 1'b1;
    else if (w_cand[P_CST]) w_grant[P_CST] = 1'b1;
  end

  // Output registers: every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulse    <= '0;
      r_throttle <= 1'b0;
      r_brake    <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_pulse    <= w_grant;
      r_throttle <= r_deb[THR];
      r_brake    <= r_deb[BRK];
      r_conflict <= w_conflict;
    end
  end

  assign throttle             = r_throttle;
  assign brake                = r_brake;
  assign set                  = r_pulse[P_SET];
  assign accel                = r_pulse[P_ACC];
  assign coast                = r_pulse[P_CST];
  assign cancel               = r_pulse[P_CAN];
  assign resume               = r_pulse[P_RES];
  assign accel_coast_conflict = r_conflict;

endmodule
